// File: rtl/tvm_dma_copy.sv
// tvm_dma_copy: device-side copy initiator for the host memory bridge.
// A start command issues one read and one write request to the bridge. Words
// are drained from the bridge read stream into a small staging FIFO and
// refilled from its head into the bridge write stream.
//
// state | meaning
// IDLE  | waiting for start; start is only sampled here
// REQ   | one-cycle host read/write request pulse
// XFER  | moving words read stream -> FIFO -> write stream
// DONE  | one-cycle completion pulse
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   start, src_addr, dst_addr, size    copy command
//   busy, done                         status
//   host_read_req/addr/size            read request to the bridge
//   host_write_req/addr/size           write request to the bridge
//   read_en, read_data, read_data_valid        bridge read stream
//   write_en, write_data, write_data_ready     bridge write stream
module tvm_dma_copy #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int SIZE_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [SIZE_WIDTH-1:0] size,
   output logic                  busy,
   output logic                  done,
   output logic                  host_read_req,
   output logic [ADDR_WIDTH-1:0] host_read_addr,
   output logic [SIZE_WIDTH-1:0] host_read_size,
   output logic                  host_write_req,
   output logic [ADDR_WIDTH-1:0] host_write_addr,
   output logic [SIZE_WIDTH-1:0] host_write_size,
   output logic                  read_en,
   input  logic [DATA_WIDTH-1:0] read_data,
   input  logic                  read_data_valid,
   output logic                  write_en,
   output logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_data_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic [SIZE_WIDTH-1:0] rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

   logic fifo_full, fifo_empty;

   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);

   assign busy            = (state_q != S_IDLE);
   assign done            = (state_q == S_DONE);
   assign host_read_req   = (state_q == S_REQ);
   assign host_write_req  = (state_q == S_REQ);
   assign host_read_addr  = src_q;
   assign host_write_addr = dst_q;
   assign host_read_size  = size_q;
   assign host_write_size = size_q;

   assign read_en  = (state_q == S_XFER) && read_data_valid && (rd_rem_q != '0) && !fifo_full;
   assign write_en = (state_q == S_XFER) && !fifo_empty && write_data_ready;
   // Gated so the data output reads 0 while nothing is staged (including after reset).
   assign write_data = fifo_empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      size_d   = size_q;
      rd_rem_d = rd_rem_q;
      wr_rem_d = wr_rem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d    = src_addr;
               dst_d    = dst_addr;
               size_d   = size;
               rd_rem_d = size;
               wr_rem_d = size;
               state_d  = (size != '0) ? S_REQ : S_DONE;
            end
         end
         S_REQ:  state_d = S_XFER;
         S_XFER: begin
            if (read_en) begin
               mem_d[wr_ptr_q] = read_data;
               wr_ptr_d        = wr_ptr_q + PW'(1);
               rd_rem_d        = rd_rem_q - SIZE_WIDTH'(1);
            end
            if (write_en) begin
               rd_ptr_d = rd_ptr_q + PW'(1);
               if (wr_rem_q != '0) wr_rem_d = wr_rem_q - SIZE_WIDTH'(1);
               if (wr_rem_q == SIZE_WIDTH'(1)) state_d = S_DONE;
            end
            // Push and pop together leave occupancy unchanged.
            if (read_en && !write_en)      count_d = count_q + CW'(1);
            else if (!read_en && write_en) count_d = count_q - CW'(1);
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         size_q   <= '0;
         rd_rem_q <= '0;
         wr_rem_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         size_q   <= size_d;
         rd_rem_q <= rd_rem_d;
         wr_rem_q <= wr_rem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the occupancy count decides what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_tvm_dma_copy.sv
// Bench for tvm_dma_copy. The source stream is a queue of random words; the
// reference result of a copy of N words is simply the first N source words in
// order, each written exactly once, with one done pulse per command.
module tb_tvm_dma_copy;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] src_addr, dst_addr, size;
   logic        busy, done;
   logic        host_read_req, host_write_req;
   logic [31:0] host_read_addr, host_write_addr, host_read_size, host_write_size;
   logic        read_en, read_data_valid, write_en, write_data_ready;
   logic [7:0]  read_data, write_data;

   always #5 clk = ~clk;

   tvm_dma_copy dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .size(size), .busy(busy), .done(done),
      .host_read_req(host_read_req), .host_read_addr(host_read_addr),
      .host_read_size(host_read_size), .host_write_req(host_write_req),
      .host_write_addr(host_write_addr), .host_write_size(host_write_size),
      .read_en(read_en), .read_data(read_data), .read_data_valid(read_data_valid),
      .write_en(write_en), .write_data(write_data), .write_data_ready(write_data_ready)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   // next-cycle drive values
   logic        nxt_rst = 1'b1, nxt_start = 1'b0, nxt_valid = 1'b0, nxt_ready = 1'b0;
   logic [31:0] nxt_src = '0, nxt_dst = '0, nxt_size = '0;

   // model / monitor state
   logic [7:0]  src_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          wcyc_q[$];
   int cyc, n_reads, n_writes, n_done, n_req, n_wreq, n_badpop;
   int req_cyc, done_cyc, busy_low_cyc;
   logic [31:0] req_raddr, req_waddr, req_rsize, req_wsize;

   task automatic clear_stats();
      got_q.delete(); wcyc_q.delete(); src_q.delete(); exp_q.delete();
      cyc = 0; n_reads = 0; n_writes = 0; n_done = 0; n_req = 0; n_wreq = 0; n_badpop = 0;
      req_cyc = -1; done_cyc = -1; busy_low_cyc = -1;
      req_raddr = '0; req_waddr = '0; req_rsize = '0; req_wsize = '0;
   endtask

   // Source stream: n copied words (expected result) followed by surplus words.
   task automatic load_source(input int n, input logic fixed);
      for (int i = 0; i < n + 8; i++) begin
         logic [7:0] w;
         w = fixed ? 8'(8'hA0 + i) : 8'($urandom_range(0, 255));
         src_q.push_back(w);
         if (i < n) exp_q.push_back(w);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rst = nxt_rst; start = nxt_start;
      src_addr = nxt_src; dst_addr = nxt_dst; size = nxt_size;
      read_data_valid = nxt_valid; write_data_ready = nxt_ready;
      read_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
      @(negedge clk);
      if (read_en) begin
         n_reads++;
         if (!read_data_valid) n_badpop++;
         if (src_q.size() > 0) void'(src_q.pop_front());
      end
      if (write_en) begin
         n_writes++;
         got_q.push_back(write_data);
         wcyc_q.push_back(cyc);
      end
      if (done) begin
         n_done++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      if (host_read_req) begin
         n_req++;
         if (req_cyc < 0) begin
            req_cyc = cyc; req_raddr = host_read_addr; req_waddr = host_write_addr;
            req_rsize = host_read_size; req_wsize = host_write_size;
         end
      end
      if (host_write_req) n_wreq++;
      if (!busy && busy_low_cyc < 0 && cyc > 0) busy_low_cyc = cyc;
      cyc++;
   endtask

   task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
      nxt_src = s; nxt_dst = d; nxt_size = n; nxt_start = 1'b1;
      step();
      nxt_start = 1'b0;
   endtask

   task automatic compare_data(input string name);
      total_cnt++;
      if (got_q.size() !== exp_q.size())
         $display("FAIL %s word count: got %0d expected %0d", name, got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL %s word %0d: got %02h expected %02h", name, i, got_q[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      nxt_rst = 1'b1; nxt_valid = 1'b1; nxt_ready = 1'b1;
      clear_stats();
      step(); step();
      total_cnt++;
      if ({busy, done, host_read_req, host_write_req, read_en, write_en} !== 6'b0 ||
          host_read_addr !== '0 || host_write_addr !== '0 || host_read_size !== '0 ||
          host_write_size !== '0 || write_data !== '0)
         $display("FAIL reset outputs: busy=%b done=%b rreq=%b wreq=%b ren=%b wen=%b wdata=%h",
                  busy, done, host_read_req, host_write_req, read_en, write_en, write_data);
      else pass_cnt++;
      nxt_rst = 1'b0;
      step();
   endtask

   task automatic test_basic_copy();
      clear_stats();
      load_source(4, 1'b1);
      nxt_valid = 1'b1; nxt_ready = 1'b1;
      issue(32'h10, 32'h40, 32'd4);
      for (int i = 0; i < 100 && n_done == 0; i++) step();
      step(); step();
      total_cnt++;
      if (n_req !== 1 || n_wreq !== 1 || req_cyc !== 1)
         $display("FAIL basic req: rd=%0d wr=%0d first_cycle=%0d expected 1/1/1", n_req, n_wreq, req_cyc);
      else pass_cnt++;
      total_cnt++;
      if (req_raddr !== 32'h10 || req_waddr !== 32'h40)
         $display("FAIL basic addr: rd=%h wr=%h expected 10/40", req_raddr, req_waddr);
      else pass_cnt++;
      total_cnt++;
      if (req_rsize !== 32'd4 || req_wsize !== 32'd4)
         $display("FAIL basic size: rd=%0d wr=%0d expected 4", req_rsize, req_wsize);
      else pass_cnt++;
      compare_data("basic");
      for (int i = 0; i < 4 && i < wcyc_q.size(); i++) begin
         total_cnt++;
         if (wcyc_q[i] !== 3 + i)
            $display("FAIL basic write cycle %0d: got %0d expected %0d", i, wcyc_q[i], 3 + i);
         else pass_cnt++;
      end
      total_cnt++;
      if (done_cyc !== 7 || n_done !== 1)
         $display("FAIL basic done: cycle %0d count %0d expected cycle 7 count 1", done_cyc, n_done);
      else pass_cnt++;
      total_cnt++;
      if (busy_low_cyc !== 8)
         $display("FAIL basic busy low: cycle %0d expected 8", busy_low_cyc);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      clear_stats();
      load_source(8, 1'b0);
      nxt_valid = 1'b1; nxt_ready = 1'b0;
      issue($urandom, $urandom, 32'd8);
      for (int i = 1; i < 10; i++) step();
      total_cnt++;
      if (n_reads !== 4 || n_writes !== 0)
         $display("FAIL backpressure pops: got %0d reads %0d writes expected 4/0", n_reads, n_writes);
      else pass_cnt++;
      total_cnt++;
      if (read_en !== 1'b0)
         $display("FAIL backpressure read_en while full: got %b expected 0", read_en);
      else pass_cnt++;
      nxt_ready = 1'b1;
      for (int i = 0; i < 100 && n_done == 0; i++) step();
      step(); step();
      compare_data("backpressure");
      total_cnt++;
      if (n_done !== 1)
         $display("FAIL backpressure done count: got %0d expected 1", n_done);
      else pass_cnt++;
   endtask

   task automatic test_bursty_source();
      clear_stats();
      load_source(6, 1'b0);
      nxt_ready = 1'b1; nxt_valid = 1'b1;
      issue($urandom, $urandom, 32'd6);
      for (int i = 0; i < 100 && n_done == 0; i++) begin
         nxt_valid = ~nxt_valid;
         step();
      end
      nxt_valid = 1'b1;
      step(); step();
      compare_data("bursty");
      total_cnt++;
      if (n_badpop !== 0 || n_reads !== 6)
         $display("FAIL bursty pops: invalid=%0d total=%0d expected 0/6", n_badpop, n_reads);
      else pass_cnt++;
      total_cnt++;
      if (n_done !== 1)
         $display("FAIL bursty done count: got %0d expected 1", n_done);
      else pass_cnt++;
   endtask

   task automatic test_zero_size();
      clear_stats();
      load_source(0, 1'b0);
      nxt_valid = 1'b1; nxt_ready = 1'b1;
      issue($urandom, $urandom, 32'd0);
      for (int i = 0; i < 5; i++) step();
      total_cnt++;
      if (done_cyc !== 1 || n_done !== 1 || busy_low_cyc !== 2)
         $display("FAIL zero done: cycle %0d count %0d busy_low %0d expected 1/1/2",
                  done_cyc, n_done, busy_low_cyc);
      else pass_cnt++;
      total_cnt++;
      if (n_req !== 0 || n_wreq !== 0 || n_reads !== 0 || n_writes !== 0)
         $display("FAIL zero activity: rreq=%0d wreq=%0d reads=%0d writes=%0d expected 0",
                  n_req, n_wreq, n_reads, n_writes);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_transfer();
      clear_stats();
      load_source(8, 1'b0);
      nxt_valid = 1'b1; nxt_ready = 1'b1;
      issue($urandom, $urandom, 32'd8);
      for (int i = 0; i < 100 && n_writes < 3; i++) step();
      total_cnt++;
      if (n_writes !== 3)
         $display("FAIL reset-mid progress: got %0d writes expected 3", n_writes);
      else pass_cnt++;
      nxt_rst = 1'b1;
      step();
      nxt_rst = 1'b0;
      step();
      total_cnt++;
      if ({busy, done, host_read_req, host_write_req, read_en, write_en} !== 6'b0 ||
          host_read_addr !== '0 || host_write_addr !== '0 || host_read_size !== '0 ||
          host_write_size !== '0 || write_data !== '0)
         $display("FAIL reset-mid outputs: busy=%b done=%b ren=%b wen=%b raddr=%h rsize=%0d wdata=%h",
                  busy, done, read_en, write_en, host_read_addr, host_read_size, write_data);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) step();
      total_cnt++;
      if (n_done !== 0)
         $display("FAIL reset-mid done pulse: got %0d expected 0", n_done);
      else pass_cnt++;
      clear_stats();
      load_source(2, 1'b0);
      issue($urandom, $urandom, 32'd2);
      for (int i = 0; i < 100 && n_done == 0; i++) step();
      step();
      compare_data("post-reset");
      total_cnt++;
      if (n_done !== 1 || done_cyc !== 5)
         $display("FAIL post-reset done: count %0d cycle %0d expected 1/5", n_done, done_cyc);
      else pass_cnt++;
   endtask

   task automatic test_start_while_busy();
      logic [31:0] s, d;
      s = $urandom; d = $urandom;
      clear_stats();
      load_source(5, 1'b0);
      nxt_valid = 1'b1; nxt_ready = 1'b1;
      issue(s, d, 32'd5);
      step(); step();
      issue(~s, ~d, 32'd3);
      for (int i = 0; i < 100 && n_done == 0; i++) step();
      for (int i = 0; i < 4; i++) step();
      compare_data("busy-start");
      total_cnt++;
      if (host_read_addr !== s || host_write_addr !== d ||
          host_read_size !== 32'd5 || host_write_size !== 32'd5)
         $display("FAIL busy-start latch: raddr=%h waddr=%h rsize=%0d wsize=%0d expected %h/%h/5/5",
                  host_read_addr, host_write_addr, host_read_size, host_write_size, s, d);
      else pass_cnt++;
      total_cnt++;
      if (n_done !== 1 || n_req !== 1)
         $display("FAIL busy-start counts: done %0d req %0d expected 1/1", n_done, n_req);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      clear_stats();
      load_source(3, 1'b0);
      nxt_valid = 1'b1; nxt_ready = 1'b1;
      issue($urandom, $urandom, 32'd3);
      for (int i = 0; i < 100 && n_done == 0; i++) step();
      // first IDLE cycle after done: a new start must be taken here
      issue(32'h77, 32'h88, 32'd1);
      for (int i = 0; i < 10; i++) step();
      total_cnt++;
      if (n_done !== 2 || n_req !== 2 || n_writes !== 4)
         $display("FAIL back-to-back: done %0d req %0d writes %0d expected 2/2/4", n_done, n_req, n_writes);
      else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; size = '0;
      read_data = '0; read_data_valid = 1'b0; write_data_ready = 1'b0;
      test_reset();
      test_basic_copy();
      test_backpressure();
      test_bursty_source();
      test_zero_size();
      test_reset_mid_transfer();
      test_start_while_busy();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
